tx_axis_arbiter: RTL

TX_AXIS_ARBITER -- requirements
Module: tx_axis_arbiter

---
 rtl/tx_axis_arbiter_pkg.sv | 13 +
 rtl/tx_axis_arbiter_skid.sv | 65 ++++++
 rtl/tx_axis_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/tx_axis_arbiter_pkg.sv
// Shared types and widths for the tx AXIS arbiter.
// State encoding plus the fixed 64-bit data / 8-bit keep beat format.
package code_defs_pkg;

    localparam int AXIS_DATA_W = 64;
    localparam int AXIS_KEEP_W = 8;

    typedef enum logic {
        ARB,
        XFER
    } tx_arb_state_t;

endpackage

// File: rtl/tx_axis_arbiter_skid.sv
// Two-entry AXIS skid buffer with registered outputs.
// The upstream ready signal comes straight from a flop.
module axis_skid_buffer
    import code_defs_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [AXIS_DATA_W-1:0] s_data,
    input  logic [AXIS_KEEP_W-1:0] s_keep,
    input  logic                   s_last,
    input  logic                   s_valid,
    output logic                   s_ready,
    output logic [AXIS_DATA_W-1:0] m_data,
    output logic [AXIS_KEEP_W-1:0] m_keep,
    output logic                   m_last,
    output logic                   m_valid,
    input  logic                   m_ready
);

    logic [AXIS_DATA_W-1:0] skid_data_q;
    logic [AXIS_KEEP_W-1:0] skid_keep_q;
    logic                   skid_last_q;
    logic                   skid_valid_q;
    logic                   accept;
    logic                   out_free;

    assign s_ready  = ~skid_valid_q;
    assign accept   = s_valid & s_ready;
    assign out_free = ~m_valid | m_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            m_data       <= '0;
            m_keep       <= '0;
            m_last       <= 1'b0;
            m_valid      <= 1'b0;
            skid_data_q  <= '0;
            skid_keep_q  <= '0;
            skid_last_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (out_free) begin
            // The parked beat always drains before new input to keep order.
            if (skid_valid_q) begin
                m_data       <= skid_data_q;
                m_keep       <= skid_keep_q;
                m_last       <= skid_last_q;
                m_valid      <= 1'b1;
                skid_valid_q <= 1'b0;
            end else if (accept) begin
                m_data  <= s_data;
                m_keep  <= s_keep;
                m_last  <= s_last;
                m_valid <= 1'b1;
            end else begin
                m_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_data_q  <= s_data;
            skid_keep_q  <= s_keep;
            skid_last_q  <= s_last;
            skid_valid_q <= 1'b1;
        end
    end

endmodule

// File: rtl/tx_axis_arbiter.sv
// Frame-level N-port AXIS arbiter feeding one tx MAC stream.
// Round-robin by default; TX_ARB_STRICT_PRIO_EN selects fixed lowest-index priority.
module tx_axis_arbiter
    import code_defs_pkg::*;
#(
    parameter int N_PORTS = 2
) (
    input  logic                             i_clk,
    input  logic                             i_reset_n,
    input  logic [N_PORTS*AXIS_DATA_W-1:0]   s_axis_tdata,
    input  logic [N_PORTS*AXIS_KEEP_W-1:0]   s_axis_tkeep,
    input  logic [N_PORTS-1:0]               s_axis_tvalid,
    input  logic [N_PORTS-1:0]               s_axis_tlast,
    output logic [N_PORTS-1:0]               s_axis_tready,
    output logic [AXIS_DATA_W-1:0]           m00_axis_tdata,
    output logic [AXIS_KEEP_W-1:0]           m00_axis_tkeep,
    output logic                             m00_axis_tvalid,
    output logic                             m00_axis_tlast,
    input  logic                             m00_axis_tready,
    output logic [N_PORTS-1:0]               o_grant
);

    localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam logic [IDX_W:0] NP = (IDX_W + 1)'(N_PORTS);

    tx_arb_state_t          state_q, state_d;
    logic [N_PORTS-1:0]     grant_q, grant_d;
    logic [N_PORTS-1:0]     sel_oh, rot;
    logic [IDX_W-1:0]       base, off, sel_idx;
    logic [IDX_W:0]         sum;
    logic                   any_req;
    logic [AXIS_DATA_W-1:0] g_data;
    logic [AXIS_KEEP_W-1:0] g_keep;
    logic                   g_valid, g_last;
    logic                   skid_ready, done;

`ifdef TX_ARB_STRICT_PRIO_EN
    assign base = '0;
`else
    logic [IDX_W-1:0] rr_ptr_q, gidx_q;

    assign base = rr_ptr_q;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            rr_ptr_q <= '0;
            gidx_q   <= '0;
        end else begin
            if (state_q == ARB && any_req)
                gidx_q <= sel_idx;
            if (done)
                rr_ptr_q <= (gidx_q == IDX_W'(N_PORTS - 1)) ? '0 : gidx_q + 1'b1;
        end
    end
`endif

    // Rotate requests so bit 0 is the port at base, then take the lowest set bit.
    always_comb begin
        any_req = |s_axis_tvalid;
        rot     = N_PORTS'({s_axis_tvalid, s_axis_tvalid} >> base);
        off     = '0;
        for (int i = N_PORTS - 1; i >= 0; i--)
            if (rot[i]) off = IDX_W'(i);
        sum     = {1'b0, base} + {1'b0, off};
        sel_idx = IDX_W'((sum >= NP) ? (sum - NP) : sum);
        sel_oh  = '0;
        for (int i = 0; i < N_PORTS; i++)
            sel_oh[i] = (sel_idx == IDX_W'(i));
    end

    always_comb begin
        g_data = '0;
        g_keep = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (grant_q[i]) begin
                g_data = g_data | s_axis_tdata[i*AXIS_DATA_W +: AXIS_DATA_W];
                g_keep = g_keep | s_axis_tkeep[i*AXIS_KEEP_W +: AXIS_KEEP_W];
            end
        end
        g_valid = (state_q == XFER) && |(s_axis_tvalid & grant_q);
        g_last  = |(s_axis_tlast & grant_q);
    end

    assign s_axis_tready = grant_q & {N_PORTS{skid_ready}};
    assign done          = g_valid && skid_ready && g_last;
    assign o_grant       = grant_q;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        unique case (state_q)
            ARB: begin
                if (any_req) begin
                    state_d = XFER;
                    grant_d = sel_oh;
                end
            end
            XFER: begin
                if (done) begin
                    state_d = ARB;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = ARB;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q <= ARB;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    axis_skid_buffer u_skid (
        .clk     (i_clk),
        .reset_n (i_reset_n),
        .s_data  (g_data),
        .s_keep  (g_keep),
        .s_last  (g_last),
        .s_valid (g_valid),
        .s_ready (skid_ready),
        .m_data  (m00_axis_tdata),
        .m_keep  (m00_axis_tkeep),
        .m_last  (m00_axis_tlast),
        .m_valid (m00_axis_tvalid),
        .m_ready (m00_axis_tready)
    );

endmodule
